centroid_updater: RTL and testbench
===================================

Name: centroid_updater

Overview:
- Parametrised, sequential successor to the single-cycle k-means accumulator.
- Accepts classified points through a valid/ready handshake and keeps per-cluster coordinate sums and counts for any dimension count D.
- On request, computes new centroids with one shared bit-serial unsigned divider instead of 2**N*D parallel dividers.
- Sits between the classifier (supplies id_class) and the centroid register bank / iteration controller.

Parameters:
- N, 8: log2 of the cluster count; 2**N clusters.
- D, 2: point dimension count, D >= 1.
- W, 32: coordinate width, unsigned.
- ACC_W, 64: per-dimension sum width; also the divider iteration count. Must satisfy ACC_W >= W.
- CNT_W, 32: per-cluster point counter width. Must satisfy CNT_W <= ACC_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  point/id_class valid
- in_ready  out  1  block accepts a point this cycle
- point  in  [W-1:0] x [D-1:0]  point coordinates
- id_class  in  N  cluster index of point
- centroids  in  [W-1:0] x [2**N-1:0][D-1:0]  current centroids; must be held stable by upstream from update_req until done
- update_req  in  1  request centroid recomputation
- busy  out  1  high while dividing
- done  out  1  one-cycle pulse when new_centroids are complete
- new_centroids  out  [W-1:0] x [2**N-1:0][D-1:0]  computed centroids
- cnt_ovf  out  1  sticky: a point was dropped because its cluster counter was saturated
- changed_cnt  out  N+1  number of clusters whose centroid changed (see Optional Feature)

Behaviour:
- Reset (clk edge with rst=1):
  - All sums and counts = 0; new_centroids = 0.
  - busy=0, done=0, cnt_ovf=0, changed_cnt=0; state=ACC.
  - Reset mid-DIV aborts the division immediately; partially written new_centroids are cleared to 0.
- States: ACC, DIV, FIN.
- ACC:
  - in_ready=1.
  - Point accepted on a cycle with in_valid&in_ready. On the next edge, sum[id_class][j] += zero-extended point[j] for all j, and count[id_class] += 1.
  - If count[id_class] == 2**CNT_W-1, the point is dropped entirely (no sum update) and cnt_ovf is set.
  - update_req=1 moves to DIV on the next edge. A point accepted in that same cycle is included in the sums.
- DIV:
  - in_ready=0, busy=1. update_req is ignored.
  - Elements are processed in order i=0..2**N-1 (outer), j=0..D-1 (inner).
  - Each element takes ACC_W+1 cycles: 1 load cycle, then ACC_W restoring-division iterations of sum/count (unsigned, truncating).
  - Result written to new_centroids[i][j] on the element's last cycle. The quotient's low W bits are written; it always fits because mean <= max coordinate.
  - If count[i]==0 (empty cluster), new_centroids[i][j] = centroids[i][j]. Empty clusters still consume the full ACC_W+1 cycles, so latency is data-independent.
- FIN (one cycle):
  - done=1, busy=0.
  - All sums/counts cleared; cnt_ovf cleared.
  - Returns to ACC on the next edge. in_ready=0 during FIN.
- Latency: done asserts exactly 2**N*D*(ACC_W+1)+1 cycles after the edge that sampled update_req.
- Simultaneous rst and any other input: rst wins.
- new_centroids holds its value between updates. It is not a function of later points.

Optional Feature:
- Macro: KMEANS_CHANGE_CNT_EN.
- Defined:
  - changed_cnt counts clusters i for which any new_centroids[i][j] != centroids[i][j] at write time.
  - Counter cleared on entering DIV; value valid with done and held until the next DIV entry.
  - Feeds the iteration controller's convergence test (changed_cnt==0).
- Undefined: changed_cnt tied to 0; no comparator logic.

Test Plan:
- Basic mean: N=1, D=2, ACC_W=64. Points (10,20), (20,40), (31,61) to cluster 0; (7,9) to cluster 1; update_req -> after 261 cycles, done=1; new_centroids[0]=(20,40), new_centroids[1]=(7,9).
- Empty cluster: centroids[1]=(5,6); no points to cluster 1; update -> new_centroids[1]=(5,6). With KMEANS_CHANGE_CNT_EN and centroids[0]=(20,40), changed_cnt=0.
- Same-cycle: point (100,100) to cluster 0 presented with update_req -> included; in_ready=0 for the following 261 cycles.
- Saturation: CNT_W=2. Four points (8,8) to cluster 0 -> fourth dropped, cnt_ovf=1, result (8,8). cnt_ovf=0 after done.
- Reset mid-DIV: assert rst 50 cycles into DIV -> next cycle busy=0, in_ready=1, new_centroids all 0, no done pulse.
- Back-to-back: after done, feed (2,4) to cluster 0 and update again -> new_centroids[0]=(2,4), showing accumulators were cleared.

Source files
------------

// File: rtl/centroid_updater.sv
`default_nettype none
// ============================================================================
// Module   : centroid_updater
// Purpose  : k-means accumulator with one shared bit-serial divider for means.
// Options  : KMEANS_CHANGE_CNT_EN enables the changed-cluster counter.
// Revision : 1.0
// ============================================================================
module centroid_updater #(
  parameter int N     = 8,
  parameter int D     = 2,
  parameter int W     = 32,
  parameter int ACC_W = 64,
  parameter int CNT_W = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [D-1:0][W-1:0]                point,
  input  logic [N-1:0]                       id_class,
  input  logic [(2**N)-1:0][D-1:0][W-1:0]    centroids,
  input  logic                               update_req,
  output logic                               busy,
  output logic                               done,
  output logic [(2**N)-1:0][D-1:0][W-1:0]    new_centroids,
  output logic                               cnt_ovf,
  output logic [N:0]                         changed_cnt
);
  localparam int C_K  = 2**N;
  localparam int C_JW = (D > 1) ? $clog2(D) : 1;
  localparam int C_PW = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {ACC = 2'd0, DIV = 2'd1, FIN = 2'd2} state_t;

  state_t                            state_q;
  logic [C_K-1:0][D-1:0][ACC_W-1:0]  sum_q;
  logic [C_K-1:0][CNT_W-1:0]         cnt_q;
  logic [C_K-1:0][D-1:0][W-1:0]      nc_q;
  logic                              in_ready_q, busy_q, done_q, ovf_q;
  logic [N-1:0]                      ci_q;
  logic [C_JW-1:0]                   dj_q;
  logic [C_PW-1:0]                   ph_q;
  logic [ACC_W-1:0]                  quo_q, rem_q, quo_d, rem_d, divisor;
  logic [ACC_W:0]                    trial;
  logic [W-1:0]                      res_d;
  logic                              last_ph, last_j, last_i;

  // One restoring-division step; quo_q holds the remaining dividend bits and
  // collects quotient bits from the bottom as they are shifted out.
  always_comb begin
    divisor = ACC_W'(cnt_q[ci_q]);
    trial   = {rem_q, quo_q[ACC_W-1]};
    if (trial >= {1'b0, divisor}) begin
      rem_d = ACC_W'(trial - {1'b0, divisor});
      quo_d = (quo_q << 1) | ACC_W'(1);
    end else begin
      rem_d = trial[ACC_W-1:0];
      quo_d = quo_q << 1;
    end
    res_d   = (cnt_q[ci_q] == '0) ? centroids[ci_q][dj_q] : quo_d[W-1:0];
    last_ph = (ph_q == C_PW'(ACC_W));
    last_j  = (dj_q == C_JW'(D - 1));
    last_i  = (ci_q == {N{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACC;
      sum_q      <= '0;
      cnt_q      <= '0;
      nc_q       <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ci_q       <= '0;
      dj_q       <= '0;
      ph_q       <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
    end else begin
      case (state_q)
        ACC: begin
          if (in_valid) begin
            if (cnt_q[id_class] == '1) begin
              ovf_q <= 1'b1;
            end else begin
              cnt_q[id_class] <= cnt_q[id_class] + 1'b1;
              for (int j = 0; j < D; j++)
                sum_q[id_class][j] <= sum_q[id_class][j] + ACC_W'(point[j]);
            end
          end
          if (update_req) begin
            state_q    <= DIV;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            ci_q       <= '0;
            dj_q       <= '0;
            ph_q       <= '0;
          end
        end
        DIV: begin
          if (ph_q == '0) begin
            quo_q <= sum_q[ci_q][dj_q];
            rem_q <= '0;
            ph_q  <= ph_q + 1'b1;
          end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            if (last_ph) begin
              nc_q[ci_q][dj_q] <= res_d;
              ph_q             <= '0;
              if (last_j) begin
                dj_q <= '0;
                if (last_i) begin
                  state_q <= FIN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  ci_q <= ci_q + 1'b1;
                end
              end else begin
                dj_q <= dj_q + 1'b1;
              end
            end else begin
              ph_q <= ph_q + 1'b1;
            end
          end
        end
        FIN: begin
          state_q    <= ACC;
          done_q     <= 1'b0;
          in_ready_q <= 1'b1;
          sum_q      <= '0;
          cnt_q      <= '0;
          ovf_q      <= 1'b0;
        end
        default: state_q <= ACC;
      endcase
    end
  end

`ifdef KMEANS_CHANGE_CNT_EN
  logic       chg_q;
  logic [N:0] changed_q;
  logic       diff;

  assign diff = (res_d != centroids[ci_q][dj_q]);

  // chg_q remembers a differing coordinate seen earlier in the same cluster.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg_q     <= 1'b0;
      changed_q <= '0;
    end else if (state_q == ACC && update_req) begin
      chg_q     <= 1'b0;
      changed_q <= '0;
    end else if (state_q == DIV && ph_q != '0 && last_ph) begin
      if (last_j) begin
        chg_q <= 1'b0;
        if (chg_q || diff) changed_q <= changed_q + 1'b1;
      end else begin
        chg_q <= chg_q | diff;
      end
    end
  end

  assign changed_cnt = changed_q;
`else
  assign changed_cnt = '0;
`endif

  assign in_ready      = in_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cnt_ovf       = ovf_q;
  assign new_centroids = nc_q;
endmodule
`default_nettype wire

// File: tb/tb_centroid_updater.sv
`default_nettype none
// Randomised self-checking bench for centroid_updater against a plain mean model.
module tb_centroid_updater;
  localparam int N = 1, D = 2, W = 32, ACC_W = 64, CNT_W = 2;
  localparam int K = 2**N;
  localparam int LAT = K*D*(ACC_W+1)+1;   // cycle index (1 = first after the sampling edge) of done

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, update_req, busy, done, cnt_ovf;
  logic [D-1:0][W-1:0] point;
  logic [N-1:0] id_class;
  logic [K-1:0][D-1:0][W-1:0] cents, new_c;
  logic [N:0] changed_cnt;

  int n_cmp = 0, n_err = 0;

  longint unsigned msum[K][D];
  int unsigned     mcnt[K];
  logic [W-1:0]    mnc[K][D];
  bit              movf;

  always #5 clk = ~clk;

  centroid_updater #(.N(N), .D(D), .W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .point(point), .id_class(id_class), .centroids(cents),
    .update_req(update_req), .busy(busy), .done(done),
    .new_centroids(new_c), .cnt_ovf(cnt_ovf), .changed_cnt(changed_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < K; i++) begin
      mcnt[i] = 0;
      for (int j = 0; j < D; j++) msum[i][j] = 0;
    end
    movf = 0;
  endtask

  task automatic model_add(input int cl, input logic [W-1:0] x, input logic [W-1:0] y);
    if (mcnt[cl] == (2**CNT_W) - 1) movf = 1;
    else begin
      mcnt[cl]++;
      msum[cl][0] += x;
      msum[cl][1] += y;
    end
  endtask

  task automatic send_point(input int cl, input logic [W-1:0] x, input logic [W-1:0] y);
    point[0] = x; point[1] = y; id_class = cl[N-1:0]; in_valid = 1;
    tick();
    in_valid = 0;
    model_add(cl, x, y);
  endtask

  task automatic run_update(input string tag, input bit with_pt, input logic [W-1:0] px,
                            input logic [W-1:0] py);
    logic [W-1:0] exp_c[K][D];
    int exp_chg, c, bad_rdy, bad_busy;
    if (with_pt) begin
      point[0] = px; point[1] = py; id_class = '0; in_valid = 1;
      model_add(0, px, py);
    end
    update_req = 1;
    tick();
    update_req = 0; in_valid = 0;
    exp_chg = 0;
    for (int i = 0; i < K; i++) begin
      bit ch = 0;
      for (int j = 0; j < D; j++) begin
        exp_c[i][j] = (mcnt[i] == 0) ? cents[i][j] : W'(msum[i][j] / mcnt[i]);
        if (exp_c[i][j] != cents[i][j]) ch = 1;
      end
      if (ch) exp_chg++;
    end
`ifndef KMEANS_CHANGE_CNT_EN
    exp_chg = 0;
`endif
    c = 1; bad_rdy = 0; bad_busy = 0;
    while (!done && c < LAT + 20) begin
      if (in_ready) bad_rdy++;
      if (!busy) bad_busy++;
      tick();
      c++;
    end
    n_cmp++; if (c !== LAT) begin n_err++; $display("FAIL %s latency: got %0d expected %0d", tag, c, LAT); end
    n_cmp++; if (bad_rdy !== 0) begin n_err++; $display("FAIL %s ready_in_div: got %0d cycles high expected 0", tag, bad_rdy); end
    n_cmp++; if (bad_busy !== 0) begin n_err++; $display("FAIL %s busy_in_div: got %0d cycles low expected 0", tag, bad_busy); end
    n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL %s fin_flags: got ready=%b busy=%b expected 0 0", tag, in_ready, busy); end
    n_cmp++; if (cnt_ovf !== movf) begin n_err++; $display("FAIL %s ovf_at_done: got %b expected %b", tag, cnt_ovf, movf); end
    n_cmp++; if (changed_cnt !== (N+1)'(exp_chg)) begin n_err++; $display("FAIL %s changed_cnt: got %0d expected %0d", tag, changed_cnt, exp_chg); end
    for (int i = 0; i < K; i++)
      for (int j = 0; j < D; j++) begin
        n_cmp++;
        if (new_c[i][j] !== exp_c[i][j]) begin
          n_err++; $display("FAIL %s new_c[%0d][%0d]: got %0d expected %0d", tag, i, j, new_c[i][j], exp_c[i][j]);
        end
        mnc[i][j] = exp_c[i][j];
      end
    model_clear();
    tick();
    n_cmp++; if (done !== 1'b0 || in_ready !== 1'b1 || cnt_ovf !== 1'b0) begin n_err++; $display("FAIL %s after_fin: got done=%b ready=%b ovf=%b expected 0 1 0", tag, done, in_ready, cnt_ovf); end
    for (int i = 0; i < K; i++)
      for (int j = 0; j < D; j++) begin
        n_cmp++;
        if (new_c[i][j] !== mnc[i][j]) begin n_err++; $display("FAIL %s held[%0d][%0d]: got %0d expected %0d", tag, i, j, new_c[i][j], mnc[i][j]); end
      end
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; update_req = 0; point = '0; id_class = '0; cents = '0;
    repeat (2) tick();
    rst = 0;
    model_clear();
    for (int i = 0; i < K; i++) for (int j = 0; j < D; j++) mnc[i][j] = '0;
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_flags: got ready=%b busy=%b done=%b expected 1 0 0", in_ready, busy, done); end
    n_cmp++; if (cnt_ovf !== 1'b0 || changed_cnt !== '0) begin n_err++; $display("FAIL reset_ovf_chg: got ovf=%b chg=%0d expected 0 0", cnt_ovf, changed_cnt); end
    n_cmp++; if (new_c !== '0) begin n_err++; $display("FAIL reset_new_c: got %h expected 0", new_c); end
  endtask

  task automatic test_basic_mean();
    send_point(0, 10, 20); send_point(0, 20, 40); send_point(0, 31, 61); send_point(1, 7, 9);
    run_update("basic", 0, 0, 0);
    n_cmp++; if (new_c[0][0] !== 32'd20 || new_c[0][1] !== 32'd40 || new_c[1][0] !== 32'd7 || new_c[1][1] !== 32'd9) begin
      n_err++; $display("FAIL basic_const: got (%0d,%0d)(%0d,%0d) expected (20,40)(7,9)", new_c[0][0], new_c[0][1], new_c[1][0], new_c[1][1]);
    end
  endtask

  task automatic test_empty_cluster();
    cents[0][0] = 20; cents[0][1] = 40; cents[1][0] = 5; cents[1][1] = 6;
    send_point(0, 10, 30); send_point(0, 30, 50);
    run_update("empty", 0, 0, 0);
  endtask

  task automatic test_same_cycle();
    send_point(1, 3, 5);
    run_update("same_cycle", 1, 100, 100);
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) send_point(0, 8, 8);
    n_cmp++; if (cnt_ovf !== 1'b1) begin n_err++; $display("FAIL sat_ovf: got %b expected 1", cnt_ovf); end
    run_update("saturation", 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    send_point(0, 2, 4);
    run_update("back_to_back", 0, 0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < K; i++) for (int j = 0; j < D; j++) cents[i][j] = $urandom;
      for (int p = 0, np = $urandom_range(0, 7); p < np; p++)
        send_point($urandom_range(0, K-1), $urandom, $urandom);
      run_update($sformatf("random%0d", r), $urandom_range(0, 1), $urandom, $urandom);
    end
  endtask

  task automatic test_reset_mid_div();
    int seen;
    send_point(0, 50, 60); send_point(1, 70, 80);
    update_req = 1; tick(); update_req = 0;
    repeat (50) tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL middiv_busy: got %b expected 1", busy); end
    rst = 1; tick(); rst = 0;
    model_clear();
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL middiv_flags: got busy=%b ready=%b done=%b expected 0 1 0", busy, in_ready, done); end
    n_cmp++; if (new_c !== '0) begin n_err++; $display("FAIL middiv_new_c: got %h expected 0", new_c); end
    seen = 0;
    repeat (LAT + 10) begin tick(); if (done) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL middiv_no_done: got %0d pulses expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_basic_mean();
    test_empty_cluster();
    test_same_cycle();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
